sccb_target: RTL

SCCB/I2C-compatible target (responder) that answers a single 7-bit device ID and exposes an 8-bit sub-address register window through a simple parallel register port. It sits on the same SCL/SDA pair as `sccb_master`. It is used in two ways: on-chip, to give the OV2640 camera/filter pipeline's configuration registers an external SCCB access path; in simulation, as a camera-register model that `sccb_master` is verified against. The block supports three-phase write (ID, sub-address, data…), two-phase write (ID, sub-address) and two-phase read (ID with R=1, data…). It does not stretch the clock.

---
 rtl/sccb_pkg.sv | 30 +++
 rtl/sccb_target_if.sv | 20 ++
 rtl/sccb_line_sync.sv | 49 ++++
 rtl/sccb_target.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB target and its line conditioner.
package sccb_pkg;

  // Width of the 7-bit device address on the bus
  localparam int DEV_ID_W = 7;

  // Bit counter: counts 0..8 within a byte plus its ACK slot
  localparam int BIT_CNT_W = 4;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_DEV_ID   = 4'd1,
    ST_DEV_ACK  = 4'd2,
    ST_SUB_ADDR = 4'd3,
    ST_SUB_ACK  = 4'd4,
    ST_WR_DATA  = 4'd5,
    ST_WR_ACK   = 4'd6,
    ST_RD_DATA  = 4'd7,
    ST_RD_ACK   = 4'd8,
    ST_IGNORE   = 4'd9
  } state_e;

  localparam state_e STATE_RESET = ST_IDLE;

  // Sub-address pointer advance, wrapping 8'hFF -> 8'h00
  function automatic logic [7:0] ptr_inc(input logic [7:0] ptr);
    return ptr + 8'd1;
  endfunction

endpackage

// File: rtl/sccb_target_if.sv
// Parallel register port between the SCCB target and the register file it serves.
interface sccb_target_if;
  logic [7:0] reg_addr_out;
  logic       reg_wr_out;
  logic [7:0] reg_wr_data_out;
  logic       reg_rd_out;
  logic [7:0] reg_rd_data_in;

  // Target side: issues addresses and strobes, consumes read data
  modport master (
    output reg_addr_out, reg_wr_out, reg_wr_data_out, reg_rd_out,
    input  reg_rd_data_in
  );

  // Register-file side
  modport slave (
    input  reg_addr_out, reg_wr_out, reg_wr_data_out, reg_rd_out,
    output reg_rd_data_in
  );
endinterface

// File: rtl/sccb_line_sync.sv
// SCL/SDA conditioning: two synchronizer FFs plus one history FF per line,
// then registered edge, START and STOP strobes (pin edge to strobe = 3 cycles).
module sccb_line_sync (
  input  logic clk,
  input  logic srst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_level
);
  logic [1:0] pin;
  assign pin = {sda, scl};

  // Per line: [0],[1] synchronizer, [2] history
  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    logic [2:0] pipe_reg;
    // Shift the pin through the synchronizer/history chain; idle bus is high
    always_ff @(posedge clk) begin
      if (srst) pipe_reg <= 3'b111;
      else      pipe_reg <= {pipe_reg[1:0], pin[gi]};
    end
  end

  logic scl_now, scl_old, sda_now, sda_old;
  assign scl_now = g_line[0].pipe_reg[1];
  assign scl_old = g_line[0].pipe_reg[2];
  assign sda_now = g_line[1].pipe_reg[1];
  assign sda_old = g_line[1].pipe_reg[2];

  // Strobes and sampled SDA are registered together so they stay aligned
  always_ff @(posedge clk) begin
    if (srst) begin
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start     <= 1'b0;
      stop      <= 1'b0;
      sda_level <= 1'b1;
    end else begin
      scl_rise  <= scl_now & ~scl_old;
      scl_fall  <= ~scl_now & scl_old;
      start     <= scl_now & scl_old & ~sda_now & sda_old;
      stop      <= scl_now & scl_old & sda_now & ~sda_old;
      sda_level <= sda_now;
    end
  end
endmodule

// File: rtl/sccb_target.sv
// SCCB/I2C target answering one device ID with an 8-bit sub-address window.
// Optional build macro: SCCB_TARGET_AUTOINC_EN (pointer auto-increment on bursts).
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [DEV_ID_W-1:0] DEV_ID      = 7'h30,
  parameter int                  HOLD_CYCLES = 2
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          SCL,
  inout  wire           SDA,
  sccb_target_if.master reg_if,
  output logic          busy_out
);
`ifdef SCCB_TARGET_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic scl_rise, scl_fall, start, stop, sda_level;

  sccb_line_sync u_sync (
    .clk      (clk_in),
    .srst     (rst_in),
    .scl      (SCL),
    .sda      (SDA),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop),
    .sda_level(sda_level)
  );

  state_e               state_reg;
  logic [BIT_CNT_W-1:0] cnt_reg;
  logic [7:0]           shift_reg, ptr_reg, wr_data_reg;
  logic                 rw_reg, wr_reg, rd_reg, rd_load_reg, rd_req_reg;
  logic                 sda_low_reg, pend_reg, pend_val_reg;
  logic [3:0]           hold_reg;
  logic                 sched_en, sched_val;
  logic [7:0]           byte_in;

  assign byte_in = {shift_reg[6:0], sda_level};

  // Decide whether this SCL fall launches an SDA change, and to what level
  always_comb begin
    sched_en  = 1'b0;
    sched_val = 1'b0;
    if (scl_fall && !start && !stop) begin
      case (state_reg)
        ST_DEV_ACK, ST_SUB_ACK, ST_WR_ACK: begin
          // First fall opens the ACK slot, second fall closes it
          sched_en  = 1'b1;
          sched_val = (cnt_reg == '0);
          if (state_reg == ST_DEV_ACK && cnt_reg != '0 && rw_reg)
            sched_val = ~shift_reg[7];
        end
        ST_RD_DATA: begin
          sched_en  = 1'b1;
          sched_val = (cnt_reg < 4'd8) ? ~shift_reg[3'(4'd7 - cnt_reg)] : 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Protocol FSM, pointer, register strobes and delayed SDA driver
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg    <= STATE_RESET;
      cnt_reg      <= '0;
      shift_reg    <= '0;
      ptr_reg      <= '0;
      wr_data_reg  <= '0;
      rw_reg       <= 1'b0;
      wr_reg       <= 1'b0;
      rd_reg       <= 1'b0;
      rd_load_reg  <= 1'b0;
      rd_req_reg   <= 1'b0;
      sda_low_reg  <= 1'b0;
      pend_reg     <= 1'b0;
      pend_val_reg <= 1'b0;
      hold_reg     <= '0;
      busy_out     <= 1'b0;
    end else begin
      wr_reg      <= 1'b0;
      rd_reg      <= rd_req_reg;
      rd_req_reg  <= 1'b0;
      rd_load_reg <= rd_reg;
      if (AUTOINC && wr_reg) ptr_reg <= ptr_inc(ptr_reg);

      // SDA only moves HOLD_CYCLES after the fall strobe, i.e. while SCL is low
      if (sched_en) begin
        if (HOLD_CYCLES <= 1) begin
          sda_low_reg <= sched_val;
        end else begin
          pend_reg     <= 1'b1;
          pend_val_reg <= sched_val;
          hold_reg     <= 4'(HOLD_CYCLES - 1);
        end
      end else if (pend_reg) begin
        if (hold_reg == 4'd1) begin
          sda_low_reg <= pend_val_reg;
          pend_reg    <= 1'b0;
        end else begin
          hold_reg <= hold_reg - 4'd1;
        end
      end

      if (stop) begin
        state_reg   <= ST_IDLE;
        sda_low_reg <= 1'b0;
        pend_reg    <= 1'b0;
        busy_out    <= 1'b0;
      end else if (start) begin
        state_reg   <= ST_DEV_ID;
        cnt_reg     <= '0;
        sda_low_reg <= 1'b0;
        pend_reg    <= 1'b0;
      end else begin
        case (state_reg)
          ST_DEV_ID, ST_SUB_ADDR, ST_WR_DATA: if (scl_rise) begin
            shift_reg <= byte_in;
            cnt_reg   <= cnt_reg + 1'b1;
            if (cnt_reg == 4'd7) begin
              cnt_reg <= '0;
              if (state_reg == ST_SUB_ADDR) begin
                ptr_reg   <= byte_in;
                state_reg <= ST_SUB_ACK;
              end else if (state_reg == ST_WR_DATA) begin
                wr_reg      <= 1'b1;
                wr_data_reg <= byte_in;
                state_reg   <= ST_WR_ACK;
              end else if (byte_in[7:1] == DEV_ID) begin
                state_reg <= ST_DEV_ACK;
                rw_reg    <= byte_in[0];
                rd_reg    <= byte_in[0];
                busy_out  <= 1'b1;
              end else begin
                state_reg <= ST_IGNORE;
                busy_out  <= 1'b0;
              end
            end
          end
          ST_DEV_ACK, ST_SUB_ACK, ST_WR_ACK: begin
            if (scl_rise) begin
              cnt_reg <= cnt_reg + 1'b1;
            end else if (scl_fall && cnt_reg != '0) begin
              cnt_reg <= '0;
              if (state_reg == ST_DEV_ACK)
                state_reg <= rw_reg ? ST_RD_DATA : ST_SUB_ADDR;
              else
                state_reg <= ST_WR_DATA;
            end
          end
          ST_RD_DATA: begin
            if (scl_rise) begin
              cnt_reg <= cnt_reg + 1'b1;
            end else if (scl_fall && cnt_reg == 4'd8) begin
              cnt_reg   <= '0;
              state_reg <= ST_RD_ACK;
            end
          end
          ST_RD_ACK: if (scl_rise) begin
            if (!sda_level) begin
              // Pointer advances first so the next read request sees it
              rd_req_reg <= 1'b1;
              if (AUTOINC) ptr_reg <= ptr_inc(ptr_reg);
              state_reg  <= ST_RD_DATA;
            end else begin
              state_reg <= ST_IGNORE;
            end
          end
          default: ;
        endcase
      end

      // Read data is captured exactly one cycle after the request
      if (rd_load_reg) shift_reg <= reg_if.reg_rd_data_in;
    end
  end

  assign SDA                    = sda_low_reg ? 1'b0 : 1'bz;
  assign reg_if.reg_addr_out    = ptr_reg;
  assign reg_if.reg_wr_out      = wr_reg;
  assign reg_if.reg_wr_data_out = wr_data_reg;
  assign reg_if.reg_rd_out      = rd_reg;
endmodule
